// File: rtl/alu_exec_unit.sv
// LEGv8 execute stage: ALU-control decode, single-cycle ALU ops and an iterative
// shift-add multiplier, with valid/ready handshakes on both sides.
module alu_exec_unit #(
   parameter int unsigned WIDTH  = 64,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [10:0]      inst31_21,
   input  logic [1:0]       ALUOp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic [3:0]       control_line,
   output logic             illegal
);

   localparam int unsigned    ShW     = $clog2(WIDTH);
   localparam logic [ShW-1:0] CntLast = ShW'(WIDTH - 1);

   localparam logic [3:0] CtlAnd   = 4'b0000;
   localparam logic [3:0] CtlOrr   = 4'b0001;
   localparam logic [3:0] CtlAdd   = 4'b0010;
   localparam logic [3:0] CtlEor   = 4'b0011;
   localparam logic [3:0] CtlSub   = 4'b0110;
   localparam logic [3:0] CtlPassB = 4'b0111;
   localparam logic [3:0] CtlLsl   = 4'b1000;
   localparam logic [3:0] CtlLsr   = 4'b1001;
   localparam logic [3:0] CtlMul   = 4'b1100;
   localparam logic [3:0] CtlIll   = 4'b1111;

   typedef enum logic {StIdle, StMul} state_e;

   state_e           state_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       flags_q;
   logic [3:0]       ctrl_q;
   logic             illegal_q;
   logic [WIDTH-1:0] a_shift_q;
   logic [WIDTH-1:0] b_shift_q;
   logic [WIDTH-1:0] acc_q;
   logic [ShW-1:0]   cnt_q;

   logic [3:0]       dec_ctrl;
   logic             dec_ill;
   logic             sub_op;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic [3:0]       alu_flags;
   logic [WIDTH-1:0] mul_sum;
   logic             accept;
   logic             accept_mul;

   always_comb begin
      dec_ctrl = CtlAdd;
      dec_ill  = 1'b0;
      unique case (ALUOp)
         2'b00: dec_ctrl = CtlAdd;
         2'b01: dec_ctrl = CtlPassB;
         2'b10: begin
            case (inst31_21)
               11'b11001011000: dec_ctrl = CtlSub;
               11'b10001010000: dec_ctrl = CtlAnd;
               11'b10101010000: dec_ctrl = CtlOrr;
               11'b11001010000: dec_ctrl = CtlEor;
               11'b11010011011: dec_ctrl = CtlLsl;
               11'b11010011010: dec_ctrl = CtlLsr;
               11'b10011011000: dec_ctrl = CtlMul;
               default:         dec_ctrl = CtlAdd;
            endcase
         end
         2'b11: begin
            // Immediate forms: bit 21 is part of the immediate, so only 10 bits decode.
            case (inst31_21[10:1])
               10'b1001000100: dec_ctrl = CtlAdd;
               10'b1101000100: dec_ctrl = CtlSub;
               10'b1001001000: dec_ctrl = CtlAnd;
               10'b1011001000: dec_ctrl = CtlOrr;
               default: begin
                  dec_ctrl = CtlIll;
                  dec_ill  = 1'b1;
               end
            endcase
         end
         default: dec_ctrl = CtlAdd;
      endcase
      if (dec_ctrl == CtlMul && !MUL_EN) begin
         dec_ctrl = CtlIll;
         dec_ill  = 1'b1;
      end
   end

   assign sub_op = (dec_ctrl == CtlSub);
   assign b_op   = sub_op ? ~b : b;
   assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_op};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (dec_ctrl)
         CtlAnd:   alu_res = a & b;
         CtlOrr:   alu_res = a | b;
         CtlEor:   alu_res = a ^ b;
         CtlPassB: alu_res = b;
         CtlLsl:   alu_res = a << b[ShW-1:0];
         CtlLsr:   alu_res = a >> b[ShW-1:0];
         CtlAdd, CtlSub: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         default:  alu_res = '0;
      endcase
   end

   assign alu_flags = dec_ill ? 4'b0000 : {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};

   assign mul_sum    = acc_q + (b_shift_q[0] ? a_shift_q : '0);
   assign in_ready   = (state_q == StIdle) && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign accept_mul = accept && (dec_ctrl == CtlMul);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= 4'b0000;
         ctrl_q      <= 4'b0000;
         illegal_q   <= 1'b0;
         a_shift_q   <= '0;
         b_shift_q   <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (accept_mul) begin
                  state_q   <= StMul;
                  a_shift_q <= a;
                  b_shift_q <= b;
                  acc_q     <= '0;
                  cnt_q     <= '0;
               end else if (accept) begin
                  result_q    <= alu_res;
                  flags_q     <= alu_flags;
                  ctrl_q      <= dec_ctrl;
                  illegal_q   <= dec_ill;
                  out_valid_q <= 1'b1;
               end
            end
            StMul: begin
               acc_q     <= mul_sum;
               a_shift_q <= a_shift_q << 1;
               b_shift_q <= b_shift_q >> 1;
               cnt_q     <= cnt_q + 1'b1;
               // Output register is guaranteed empty here: entry required a free slot.
               if (cnt_q == CntLast) begin
                  result_q    <= mul_sum;
                  flags_q     <= {mul_sum[WIDTH-1], mul_sum == '0, 2'b00};
                  ctrl_q      <= CtlMul;
                  illegal_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_valid    = out_valid_q;
   assign result       = result_q;
   assign flags        = flags_q;
   assign control_line = ctrl_q;
   assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench: an 8-bit MUL-capable unit under random traffic and a 64-bit
// unit without MUL under directed cases.
module tb_alu_exec_unit;

   typedef struct {
      logic [63:0] res;
      logic [3:0]  fl;
      logic [3:0]  ctl;
      logic        ill;
      int          rdy;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        iv8, ir8, ov8, or8, ill8;
   logic [10:0] inst8;
   logic [1:0]  op8;
   logic [7:0]  a8, b8, res8;
   logic [3:0]  fl8, ctl8;

   logic        iv64, ir64, ov64, or64, ill64;
   logic [10:0] inst64;
   logic [1:0]  op64;
   logic [63:0] a64, b64, res64;
   logic [3:0]  fl64, ctl64;

   alu_exec_unit #(.WIDTH(8), .MUL_EN(1'b1)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .inst31_21(inst8),
      .ALUOp(op8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .result(res8),
      .flags(fl8), .control_line(ctl8), .illegal(ill8)
   );

   alu_exec_unit #(.WIDTH(64), .MUL_EN(1'b0)) u_dut64 (
      .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64), .inst31_21(inst64),
      .ALUOp(op64), .a(a64), .b(b64), .out_valid(ov64), .out_ready(or64), .result(res64),
      .flags(fl64), .control_line(ctl64), .illegal(ill64)
   );

   exp_t q8[$];
   exp_t q64[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   busy_until = 0;
   int   or_mode = 0;
   bit   fresh8 = 1'b1;
   bit   fresh64 = 1'b1;

   logic [10:0] rtab [7] = '{11'b11001011000, 11'b10001010000, 11'b10101010000,
                             11'b11001010000, 11'b11010011011, 11'b11010011010,
                             11'b10011011000};
   logic [9:0]  itab [4] = '{10'b1001000100, 10'b1101000100, 10'b1001001000,
                             10'b1011001000};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: decode table and plain arithmetic on masked operands.
   function automatic exp_t model(int w, bit mul_en, logic [10:0] inst, logic [1:0] op,
                                  logic [63:0] av_in, logic [63:0] bv_in);
      exp_t        e;
      logic [63:0] mask, av, bv, r;
      logic [64:0] s;
      logic        c, v, ill;
      logic [3:0]  ctl;
      int          sh;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      av = av_in & mask;
      bv = bv_in & mask;
      c = 1'b0; v = 1'b0; ill = 1'b0; r = '0;
      if (op == 2'd0) ctl = 4'b0010;
      else if (op == 2'd1) ctl = 4'b0111;
      else if (op == 2'd2) begin
         ctl = 4'b0010;
         if (inst == 11'b11001011000) ctl = 4'b0110;
         if (inst == 11'b10001010000) ctl = 4'b0000;
         if (inst == 11'b10101010000) ctl = 4'b0001;
         if (inst == 11'b11001010000) ctl = 4'b0011;
         if (inst == 11'b11010011011) ctl = 4'b1000;
         if (inst == 11'b11010011010) ctl = 4'b1001;
         if (inst == 11'b10011011000) ctl = 4'b1100;
      end else begin
         ctl = 4'b1111; ill = 1'b1;
         if (inst[10:1] == 10'b1001000100) begin ctl = 4'b0010; ill = 1'b0; end
         if (inst[10:1] == 10'b1101000100) begin ctl = 4'b0110; ill = 1'b0; end
         if (inst[10:1] == 10'b1001001000) begin ctl = 4'b0000; ill = 1'b0; end
         if (inst[10:1] == 10'b1011001000) begin ctl = 4'b0001; ill = 1'b0; end
      end
      if (ctl == 4'b1100 && !mul_en) begin ctl = 4'b1111; ill = 1'b1; end
      sh = int'(bv % 64'(w));
      case (ctl)
         4'b0010: begin
            s = {1'b0, av} + {1'b0, bv};
            r = s[63:0] & mask;
            c = s[w];
            v = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
         end
         4'b0110: begin
            s = {1'b0, av} + {1'b0, (~bv) & mask} + 65'd1;
            r = s[63:0] & mask;
            c = s[w];
            v = (av[w-1] != bv[w-1]) && (r[w-1] != av[w-1]);
         end
         4'b0000: r = av & bv;
         4'b0001: r = av | bv;
         4'b0011: r = av ^ bv;
         4'b0111: r = bv;
         4'b1000: r = (av << sh) & mask;
         4'b1001: r = av >> sh;
         4'b1100: r = (av * bv) & mask;
         default: r = '0;
      endcase
      e.res = r;
      e.ctl = ctl;
      e.ill = ill;
      e.fl  = ill ? 4'b0000 : {r[w-1], r == 64'd0, c, v};
      e.rdy = 0;
      return e;
   endfunction

   task automatic drive_or();
      if (or_mode == 1) or8 = 1'b1;
      else if (or_mode == 2) or8 = 1'b0;
      else or8 = ($urandom_range(0, 3) != 0);
   endtask

   task automatic chk_ready8();
      check("in_ready8", ir8, (cyc >= busy_until) && (!ov8 || or8));
   endtask

   task automatic issue8(logic [10:0] inst, logic [1:0] op, logic [7:0] av, logic [7:0] bv);
      int   waited = 0;
      bit   done = 1'b0;
      exp_t e;
      while (!done) begin
         @(negedge clk);
         iv8 = 1'b1; inst8 = inst; op8 = op; a8 = av; b8 = bv;
         drive_or();
         #1;
         chk_ready8();
         if (ir8) begin
            e = model(8, 1'b1, inst, op, {56'd0, av}, {56'd0, bv});
            e.rdy = cyc + 1 + ((e.ctl == 4'b1100) ? 8 : 0);
            if (e.ctl == 4'b1100) busy_until = cyc + 1 + 8;
            q8.push_back(e);
            done = 1'b1;
         end else if (++waited > 40) begin
            tests++; fails++;
            $display("FAIL accept_timeout8: in_ready stayed 0 expected 1 within 40 cycles");
            done = 1'b1;
         end
      end
   endtask

   task automatic idle8(int n);
      repeat (n) begin
         @(negedge clk);
         iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
         drive_or();
         #1;
         chk_ready8();
      end
   endtask

   task automatic issue64(logic [10:0] inst, logic [1:0] op, logic [63:0] av, logic [63:0] bv,
                          logic [63:0] res, logic [3:0] fl, logic [3:0] ctl, logic ill);
      exp_t e;
      @(negedge clk);
      iv64 = 1'b1; inst64 = inst; op64 = op; a64 = av; b64 = bv;
      #1;
      check("in_ready64", ir64, 1'b1);
      e.res = res; e.fl = fl; e.ctl = ctl; e.ill = ill; e.rdy = cyc + 1;
      q64.push_back(e);
      @(negedge clk);
      iv64 = 1'b0;
   endtask

   function automatic logic [7:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 8'h00;
         1: return 8'hFF;
         2: return 8'h80;
         3: return 8'h7F;
         default: return 8'($urandom);
      endcase
   endfunction

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!reset) begin
         if (ov8) begin
            if (q8.size() == 0) begin
               tests++; fails++;
               $display("FAIL spurious8: out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = q8[0];
               check("result8", res8, e.res);
               check("flags8", fl8, e.fl);
               check("ctrl8", ctl8, e.ctl);
               check("illegal8", ill8, e.ill);
               if (fresh8) begin
                  check("latency8", 64'(cyc), 64'(e.rdy));
                  fresh8 = 1'b0;
               end
               if (or8) begin
                  void'(q8.pop_front());
                  fresh8 = 1'b1;
               end
            end
         end else if (q8.size() != 0 && fresh8 && cyc == q8[0].rdy) begin
            tests++; fails++;
            $display("FAIL late8: out_valid=0 expected 1 (cycle %0d)", cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!reset) begin
         if (ov64) begin
            if (q64.size() == 0) begin
               tests++; fails++;
               $display("FAIL spurious64: out_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
               e = q64[0];
               check("result64", res64, e.res);
               check("flags64", fl64, e.fl);
               check("ctrl64", ctl64, e.ctl);
               check("illegal64", ill64, e.ill);
               if (fresh64) begin
                  check("latency64", 64'(cyc), 64'(e.rdy));
                  fresh64 = 1'b0;
               end
               if (or64) begin
                  void'(q64.pop_front());
                  fresh64 = 1'b1;
               end
            end
         end else if (q64.size() != 0 && fresh64 && cyc == q64[0].rdy) begin
            tests++; fails++;
            $display("FAIL late64: out_valid=0 expected 1 (cycle %0d)", cyc);
         end
      end
   end

   initial begin
      logic [10:0] inst;
      logic [1:0]  op;
      int          k;
      reset = 1'b1;
      iv8 = 1'b0; inst8 = '0; op8 = '0; a8 = '0; b8 = '0; or8 = 1'b0;
      iv64 = 1'b0; inst64 = '0; op64 = '0; a64 = '0; b64 = '0; or64 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid8", ov8, 1'b0);
      check("rst_result8", res8, 8'h00);
      check("rst_flags8", fl8, 4'h0);
      check("rst_ctrl8", ctl8, 4'h0);
      check("rst_illegal8", ill8, 1'b0);
      check("rst_in_ready8", ir8, 1'b1);
      check("rst_out_valid64", ov64, 1'b0);
      check("rst_result64", res64, 64'h0);
      reset = 1'b0;

      // 64-bit unit, MUL disabled
      issue64(11'h000, 2'b00, 64'd5, 64'd7, 64'd12, 4'b0000, 4'b0010, 1'b0);
      issue64(11'b11001011000, 2'b10, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000,
              4'b0110, 1'b0);
      issue64(11'b11001011000, 2'b10, 64'd9, 64'd9, 64'd0, 4'b0110, 4'b0110, 1'b0);
      issue64(11'b10011011000, 2'b10, 64'd13, 64'd11, 64'd0, 4'b0000, 4'b1111, 1'b1);
      issue64(11'b11111111111, 2'b11, 64'd1, 64'd2, 64'd0, 4'b0000, 4'b1111, 1'b1);
      issue64(11'b10010001001, 2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
              64'h8000_0000_0000_0000, 4'b1001, 4'b0010, 1'b0);
      issue64(11'b10110010000, 2'b11, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 4'b0001, 1'b0);

      // 8-bit unit, directed
      or_mode = 1;
      issue8(11'h000, 2'b00, 8'd5, 8'd7);
      issue8(11'b11010011011, 2'b10, 8'h81, 8'd3);
      issue8(11'b11010011010, 2'b10, 8'h81, 8'd7);
      issue8(11'b11001010000, 2'b10, 8'hF0, 8'h3C);
      issue8(11'b10011011000, 2'b10, 8'd13, 8'd11);
      issue8(11'h000, 2'b00, 8'd1, 8'd1);

      // Backpressure then a queued ORR on the draining edge
      idle8(2);
      or_mode = 2;
      issue8(11'h000, 2'b00, 8'd100, 8'd27);
      idle8(3);
      or_mode = 1;
      issue8(11'b10101010000, 2'b10, 8'h0F, 8'h30);

      // Reset four cycles into a MUL
      idle8(2);
      issue8(11'b10011011000, 2'b10, 8'd13, 8'd11);
      idle8(3);
      @(negedge clk);
      reset = 1'b1; iv8 = 1'b0; or8 = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      q8.delete();
      q64.delete();
      fresh8 = 1'b1; fresh64 = 1'b1; busy_until = 0;
      #1;
      check("mulabort_out_valid8", ov8, 1'b0);
      chk_ready8();
      issue8(11'h000, 2'b00, 8'd200, 8'd100);
      issue8(11'b11111111111, 2'b11, 8'd1, 8'd2);

      // Random traffic
      or_mode = 0;
      repeat (300) begin
         k = $urandom_range(0, 9);
         if (k == 0) begin op = 2'b00; inst = 11'($urandom); end
         else if (k == 1) begin op = 2'b01; inst = 11'($urandom); end
         else if (k < 8) begin
            op = 2'b10;
            k = $urandom_range(0, 7);
            inst = (k < 7) ? rtab[k] : 11'($urandom);
         end else begin
            op = 2'b11;
            k = $urandom_range(0, 4);
            inst = (k < 4) ? {itab[k], 1'($urandom)} : 11'($urandom);
         end
         issue8(inst, op, rand_opnd(), rand_opnd());
         if ($urandom_range(0, 3) == 0) idle8($urandom_range(1, 3));
      end

      or_mode = 1;
      k = 0;
      while (q8.size() != 0 && k < 100) begin
         idle8(1);
         k++;
      end
      idle8(2);
      check("drain8", 64'(q8.size()), 64'd0);
      check("drain64", 64'(q64.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
